// File: rtl/pipe_hazard_ctrl_if.sv
// ============================================================================
// Module  : pipe_hazard_ctrl_if
// Brief   : Pipeline-stage status and hazard-control bundle for pipe_hazard_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface pipe_hazard_ctrl_if;
  logic       dof_valid;
  logic       dof_ma;
  logic       dof_mb;
  logic [2:0] dof_aa;
  logic [2:0] dof_ba;
  logic       ex_valid;
  logic       ex_rw;
  logic       ex_z;
  logic [2:0] ex_da;
  logic [1:0] ex_bs;
  logic       wb_valid;
  logic       wb_rw;
  logic [2:0] wb_da;
  logic       dbg_halt;
  logic       dbg_step;
  logic       cnt_clr;
  logic       pc_hold;
  logic       dof_hold;
  logic       ex_bubble;
  logic       pc_load;
  logic       flush;
  logic       halted;
  logic [1:0] state;
  logic [7:0] stall_cnt;
  logic [7:0] flush_cnt;

  modport master (
    output dof_valid, dof_ma, dof_mb, dof_aa, dof_ba,
    output ex_valid, ex_rw, ex_z, ex_da, ex_bs,
    output wb_valid, wb_rw, wb_da,
    output dbg_halt, dbg_step, cnt_clr,
    input  pc_hold, dof_hold, ex_bubble, pc_load, flush, halted,
    input  state, stall_cnt, flush_cnt
  );

  modport slave (
    input  dof_valid, dof_ma, dof_mb, dof_aa, dof_ba,
    input  ex_valid, ex_rw, ex_z, ex_da, ex_bs,
    input  wb_valid, wb_rw, wb_da,
    input  dbg_halt, dbg_step, cnt_clr,
    output pc_hold, dof_hold, ex_bubble, pc_load, flush, halted,
    output state, stall_cnt, flush_cnt
  );
endinterface

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module  : pipe_hazard_ctrl
// Brief   : RAW-hazard stall, branch flush and debug halt/step control.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl (
  input  wire logic          clk,
  input  wire logic          reset,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;
  localparam logic [1:0] S_STEP   = 2'd3;
  localparam logic [7:0] C_CNT_MAX = 8'hFF;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [7:0] r_stall_cnt;
  logic [7:0] r_flush_cnt;
  logic       w_a_hit;
  logic       w_b_hit;
  logic       w_hazard;
  logic       w_taken;
  logic       w_stall;
  logic       w_issue;
  logic       w_pc_hold;
  logic       w_dof_hold;
  logic       w_ex_bubble;
  logic       w_pc_load;
  logic       w_flush;
  logic       w_halted;
  logic       w_count_stall;

  // R0 is a real register here, so address 0 matches like any other.
  assign w_a_hit  = (bus.ex_valid & bus.ex_rw & (bus.ex_da == bus.dof_aa)) |
                    (bus.wb_valid & bus.wb_rw & (bus.wb_da == bus.dof_aa));
  assign w_b_hit  = (bus.ex_valid & bus.ex_rw & (bus.ex_da == bus.dof_ba)) |
                    (bus.wb_valid & bus.wb_rw & (bus.wb_da == bus.dof_ba));
  assign w_hazard = bus.dof_valid & ((~bus.dof_ma & w_a_hit) | (~bus.dof_mb & w_b_hit));
  assign w_taken  = bus.ex_valid & ((bus.ex_bs == 2'b11) |
                                    ((bus.ex_bs == 2'b01) &  bus.ex_z) |
                                    ((bus.ex_bs == 2'b10) & ~bus.ex_z));
  assign w_stall  = w_hazard & ~w_taken;
  assign w_issue  = bus.dof_valid & ~w_hazard;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN: begin
        if (bus.dbg_halt) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!bus.dbg_halt)                         w_state_nxt = S_RUN;
        else if (!bus.ex_valid && !bus.wb_valid)   w_state_nxt = S_HALTED;
      end
      S_HALTED: begin
        if (!bus.dbg_halt)     w_state_nxt = S_RUN;
        else if (bus.dbg_step) w_state_nxt = S_STEP;
      end
      S_STEP: begin
        if (w_issue) w_state_nxt = S_DRAIN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    w_pc_hold     = 1'b0;
    w_dof_hold    = 1'b0;
    w_ex_bubble   = 1'b0;
    w_pc_load     = 1'b0;
    w_flush       = 1'b0;
    w_halted      = 1'b0;
    w_count_stall = 1'b0;
    if (!reset) begin
      w_ex_bubble = 1'b1;
      w_flush     = 1'b1;
    end else begin
      // A taken branch wins over a stall; the PC gives pc_load priority over pc_hold.
      w_pc_load = w_taken;
      w_flush   = w_taken;
      case (r_state)
        S_RUN, S_STEP: begin
          w_pc_hold     = w_stall;
          w_dof_hold    = w_stall;
          w_ex_bubble   = w_stall;
          w_count_stall = w_stall;
        end
        S_DRAIN: begin
          w_pc_hold   = 1'b1;
          w_dof_hold  = 1'b1;
          w_ex_bubble = 1'b1;
        end
        S_HALTED: begin
          w_pc_hold   = 1'b1;
          w_dof_hold  = 1'b1;
          w_ex_bubble = 1'b1;
          w_halted    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || bus.cnt_clr) begin
      r_stall_cnt <= 8'd0;
      r_flush_cnt <= 8'd0;
    end else begin
      if (w_count_stall && (r_stall_cnt != C_CNT_MAX)) r_stall_cnt <= r_stall_cnt + 8'd1;
      if (w_taken && (r_flush_cnt != C_CNT_MAX))       r_flush_cnt <= r_flush_cnt + 8'd1;
    end
  end

  assign bus.pc_hold   = w_pc_hold;
  assign bus.dof_hold  = w_dof_hold;
  assign bus.ex_bubble = w_ex_bubble;
  assign bus.pc_load   = w_pc_load;
  assign bus.flush     = w_flush;
  assign bus.halted    = w_halted;
  assign bus.state     = r_state;
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;

endmodule

`default_nettype wire
